// File: rtl/ifetch_buf_pkg.sv
// ifetch_buf_pkg: core-wide widths and the fetch-slot record shared by the fetch path.
package ifetch_buf_pkg;
   localparam int CORE_PCW = 27;
   localparam int CORE_IW = 32;
   typedef struct packed {
      logic [CORE_PCW-1:0] pc;
      logic [CORE_IW-1:0] instr;
      logic filled;
   } slot_t;
endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: in-order instruction fetch buffer decoupling PC issue from memory response and decode.
module ifetch_buf import ifetch_buf_pkg::*; #(
   parameter int DEPTH = 4,
   parameter int PCW = CORE_PCW,
   parameter int IW = CORE_IW
) (
   input  logic clk,
   input  logic rst,
   input  logic [PCW-1:0] pc,
   input  logic redirect,
   output logic n_stall,
   output logic imem_req,
   output logic [PCW-1:0] imem_addr,
   input  logic imem_gnt,
   input  logic imem_rvalid,
   input  logic [IW-1:0] imem_rdata,
   output logic inst_valid,
   output logic [IW-1:0] inst,
   output logic [PCW-1:0] inst_pc,
   input  logic inst_ready
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   slot_t slots [DEPTH];
   logic [PW-1:0] head, fill, alloc;
   logic [CW-1:0] cnt, outstanding, kill_cnt;
   logic issue, rv_ok, kill, fill_en, pop;
   // killed requests still hold credit, so they count against the window
   assign imem_req = !rst && !redirect && (cnt + kill_cnt < CW'(DEPTH));
   assign imem_addr = pc;
   assign issue = imem_req && imem_gnt;
   assign n_stall = !rst && (issue || redirect);
   assign rv_ok = imem_rvalid && outstanding != '0;
   assign kill = rv_ok && kill_cnt != '0;
   assign fill_en = rv_ok && kill_cnt == '0 && !redirect;
   assign inst_valid = slots[head].filled && !redirect;
   assign inst = slots[head].instr;
   assign inst_pc = slots[head].pc;
   assign pop = inst_valid && inst_ready;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
         head <= '0;
         fill <= '0;
         alloc <= '0;
         cnt <= '0;
         outstanding <= '0;
         kill_cnt <= '0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(rv_ok);
         if (redirect) begin
            for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
            head <= alloc;
            fill <= alloc;
            cnt <= '0;
            kill_cnt <= outstanding - CW'(rv_ok);
         end else begin
            if (issue) begin
               slots[alloc].pc <= pc;
               slots[alloc].filled <= 1'b0;
               alloc <= alloc + 1'b1;
            end
            if (fill_en) begin
               slots[fill].instr <= imem_rdata;
               slots[fill].filled <= 1'b1;
               fill <= fill + 1'b1;
            end
            if (pop) begin
               slots[head].filled <= 1'b0;
               head <= head + 1'b1;
            end
            cnt <= cnt + CW'(issue) - CW'(pop);
            kill_cnt <= kill_cnt - CW'(kill);
         end
      end
   end
   assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && outstanding == '0))
      else $warning("ifetch_buf: imem_rvalid with no request outstanding, ignored");
endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: directed scenario checks for the fetch buffer.
module tb_ifetch_buf;
   logic clk = 1'b0, rst = 1'b1;
   logic [26:0] pc = '0;
   logic redirect = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
   logic [31:0] rdata = '0;
   logic n_stall, imem_req, inst_valid;
   logic [26:0] imem_addr, inst_pc;
   logic [31:0] inst;
   int errors = 0, checks = 0;
   ifetch_buf dut (
      .clk(clk), .rst(rst), .pc(pc), .redirect(redirect), .n_stall(n_stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(gnt),
      .imem_rvalid(rvalid), .imem_rdata(rdata), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .inst_ready(ready)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] d(input logic [26:0] a);
      return 32'hA800_0000 | {5'b0, a};
   endfunction
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
      checks++; if (n_stall !== 1'b0) begin errors++; $display("FAIL rst_nstall got %b exp 0", n_stall); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
      checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst); end
      checks++; if (inst_pc !== 27'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", inst_pc); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask
   task automatic test_straight;
      ready = 1; gnt = 1; pc = 27'h3F8C;
      #1;
      checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL sl_nstall0 got %b exp 1", n_stall); end
      checks++; if (imem_addr !== 27'h3F8C) begin errors++; $display("FAIL sl_addr got %h exp 3f8c", imem_addr); end
      cyc;
      pc = 27'h3F90; rvalid = 1; rdata = d(27'h3F8C);
      #1;
      checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL sl_nstall1 got %b exp 1", n_stall); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL sl_valid1 got %b exp 0", inst_valid); end
      cyc;
      pc = 27'h3F94; rdata = d(27'h3F90);
      #1;
      checks++; if (n_stall !== 1'b1) begin errors++; $display("FAIL sl_nstall2 got %b exp 1", n_stall); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h3F8C) begin errors++; $display("FAIL sl_pc0 got %b/%h exp 1/3f8c", inst_valid, inst_pc); end
      checks++; if (inst !== d(27'h3F8C)) begin errors++; $display("FAIL sl_inst0 got %h exp %h", inst, d(27'h3F8C)); end
      cyc;
      gnt = 0; rdata = d(27'h3F94);
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h3F90) begin errors++; $display("FAIL sl_pc1 got %b/%h exp 1/3f90", inst_valid, inst_pc); end
      cyc;
      rvalid = 0;
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h3F94) begin errors++; $display("FAIL sl_pc2 got %b/%h exp 1/3f94", inst_valid, inst_pc); end
      checks++; if (inst !== d(27'h3F94)) begin errors++; $display("FAIL sl_inst2 got %h exp %h", inst, d(27'h3F94)); end
      cyc;
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL sl_empty got %b exp 0", inst_valid); end
   endtask
   task automatic test_back_pressure;
      logic [26:0] exp_pc [4] = '{27'h104, 27'h108, 27'h10C, 27'h110};
      ready = 0; gnt = 1; pc = 27'h100;
      cyc;
      pc = 27'h104; rvalid = 1; rdata = d(27'h100);
      cyc;
      pc = 27'h108; rdata = d(27'h104);
      cyc;
      pc = 27'h10C; rdata = d(27'h108);
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_req3 got %b exp 1", imem_req); end
      cyc;
      pc = 27'h110; rdata = d(27'h10C);
      #1;
      checks++; if (imem_req !== 1'b0 || n_stall !== 1'b0) begin errors++; $display("FAIL bp_full got req=%b ns=%b exp 0/0", imem_req, n_stall); end
      cyc;
      rvalid = 0; ready = 1;
      #1;
      checks++; if (imem_req !== 1'b0 || n_stall !== 1'b0) begin errors++; $display("FAIL bp_full_pop got req=%b ns=%b exp 0/0", imem_req, n_stall); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h100) begin errors++; $display("FAIL bp_head got %b/%h exp 1/100", inst_valid, inst_pc); end
      cyc;
      ready = 0;
      #1;
      checks++; if (imem_req !== 1'b1 || n_stall !== 1'b1) begin errors++; $display("FAIL bp_resume got req=%b ns=%b exp 1/1", imem_req, n_stall); end
      cyc;
      gnt = 0; rvalid = 1; rdata = d(27'h110);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_refull got %b exp 0", imem_req); end
      cyc;
      rvalid = 0; ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] || inst !== d(exp_pc[i])) begin errors++; $display("FAIL bp_drain%0d got %b/%h/%h exp 1/%h/%h", i, inst_valid, inst_pc, inst, exp_pc[i], d(exp_pc[i])); end
         cyc;
      end
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", inst_valid); end
      ready = 0;
   endtask
   task automatic test_redirect;
      gnt = 1; pc = 27'h200;
      cyc;
      pc = 27'h204;
      cyc;
      redirect = 1;
      #1;
      checks++; if (n_stall !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL rd_cycle got ns=%b req=%b exp 1/0", n_stall, imem_req); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %b exp 0", inst_valid); end
      cyc;
      redirect = 0; pc = 27'h300; rvalid = 1; rdata = 32'hDEAD_0001;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_reissue got %b exp 1", imem_req); end
      cyc;
      gnt = 0; rdata = 32'hDEAD_0002;
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_kill1 got %b exp 0", inst_valid); end
      cyc;
      rvalid = 0;
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_kill2 got %b exp 0", inst_valid); end
      cyc;
      rvalid = 1; rdata = d(27'h300);
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_wait got %b exp 0", inst_valid); end
      cyc;
      rvalid = 0; ready = 1;
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h300 || inst !== d(27'h300)) begin errors++; $display("FAIL rd_npc got %b/%h/%h exp 1/300/%h", inst_valid, inst_pc, inst, d(27'h300)); end
      cyc;
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rd_empty got %b exp 0", inst_valid); end
      ready = 0;
   endtask
   task automatic test_back_to_back;
      gnt = 1; pc = 27'h400;
      cyc;
      pc = 27'h404; rvalid = 1; rdata = d(27'h400);
      cyc;
      pc = 27'h408; rdata = d(27'h404); ready = 1;
      #1;
      checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b1 || inst_pc !== 27'h400) begin errors++; $display("FAIL bb_all got req=%b %b/%h exp 1 1/400", imem_req, inst_valid, inst_pc); end
      cyc;
      gnt = 0; rdata = d(27'h408);
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h404 || inst !== d(27'h404)) begin errors++; $display("FAIL bb_1 got %b/%h/%h exp 1/404/%h", inst_valid, inst_pc, inst, d(27'h404)); end
      cyc;
      rvalid = 0;
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h408 || inst !== d(27'h408)) begin errors++; $display("FAIL bb_2 got %b/%h/%h exp 1/408/%h", inst_valid, inst_pc, inst, d(27'h408)); end
      cyc;
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL bb_empty got %b exp 0", inst_valid); end
      ready = 0;
   endtask
   task automatic test_async_reset;
      gnt = 1; pc = 27'h500;
      cyc;
      pc = 27'h504; rvalid = 1; rdata = d(27'h500);
      cyc;
      pc = 27'h508; rvalid = 0;
      #1;
      checks++; if (inst_valid !== 1'b1 || n_stall !== 1'b1) begin errors++; $display("FAIL ar_pre got %b/%b exp 1/1", inst_valid, n_stall); end
      #1 rst = 1;
      #1;
      checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0 || n_stall !== 1'b0) begin errors++; $display("FAIL ar_drop got v=%b req=%b ns=%b exp 0/0/0", inst_valid, imem_req, n_stall); end
      checks++; if (inst_pc !== 27'h0 || inst !== 32'h0) begin errors++; $display("FAIL ar_zero got %h/%h exp 0/0", inst_pc, inst); end
      @(posedge clk);
      #1 rst = 0; gnt = 0; rvalid = 1; rdata = 32'hBAD0_0000;
      cyc;
      rvalid = 0;
      #1;
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ar_stray got %b exp 0", inst_valid); end
      gnt = 1; pc = 27'h600;
      cyc;
      gnt = 0; rvalid = 1; rdata = d(27'h600);
      cyc;
      rvalid = 0;
      #1;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 27'h600 || inst !== d(27'h600)) begin errors++; $display("FAIL ar_after got %b/%h/%h exp 1/600/%h", inst_valid, inst_pc, inst, d(27'h600)); end
   endtask
   initial begin
      test_reset;
      test_straight;
      test_back_pressure;
      test_redirect;
      test_back_to_back;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
